// File: rtl/ysyx_bus_arb_pkg.sv
// rtl/ysyx_bus_arb_pkg.sv - shared state, owner and response encodings for the bus arbiter
package ysyx_bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_rr_arb2.sv
// rtl/ysyx_rr_arb2.sv - combinational two-way round-robin picker (req[0]=IFU, req[1]=LSU)
module ysyx_rr_arb2
  import ysyx_bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_owner == OWN_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_bus_arb.sv
// rtl/ysyx_bus_arb.sv - shares one AXI-lite master between the fetch and load/store ports,
// one transaction outstanding, round-robin ownership
module ysyx_bus_arb
  import ysyx_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rvalid,
  output logic                ifu_rerr,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  output logic                lsu_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  state_e              state;
  logic                last_owner;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                aw_done;
  logic                w_done;
  logic                r_fire;
  logic                b_fire;

  assign req = {lsu_arvalid | lsu_awvalid, ifu_arvalid};

  ysyx_rr_arb2 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .gnt        (gnt)
  );

  // last_owner doubles as the current owner once a grant has been made
  assign aw_done = !m_awvalid || m_awready;
  assign w_done  = !m_wvalid  || m_wready;
  assign r_fire  = (state == ST_RD_DATA) && m_rvalid;
  assign b_fire  = (state == ST_WR_RESP) && m_bvalid;

  assign ifu_rvalid = r_fire && (last_owner == OWN_IFU);
  assign lsu_rvalid = r_fire && (last_owner == OWN_LSU);
  assign lsu_bvalid = b_fire;
  assign ifu_rerr   = ifu_rvalid && resp_is_err(m_rresp);
  assign lsu_err    = (lsu_rvalid && resp_is_err(m_rresp)) || (lsu_bvalid && resp_is_err(m_bresp));
  assign ifu_rdata  = m_rdata;
  assign lsu_rdata  = m_rdata;
  assign m_araddr   = addr_q;
  assign m_awaddr   = addr_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = wstrb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_owner <= OWN_LSU;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt[0]) begin
            last_owner <= OWN_IFU;
            addr_q     <= ifu_araddr;
            m_arvalid  <= 1'b1;
            state      <= ST_RD_ADDR;
          end else if (gnt[1]) begin
            last_owner <= OWN_LSU;
            if (lsu_awvalid) begin
              addr_q    <= lsu_awaddr;
              wdata_q   <= lsu_wdata;
              wstrb_q   <= lsu_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= ST_WR_ADDR;
            end else begin
              addr_q    <= lsu_araddr;
              m_arvalid <= 1'b1;
              state     <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WR_ADDR: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_bready <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_bus_arb.md
Name: ysyx_bus_arb

Overview:
- Two-requester arbiter sharing the core's single memory bus master between the instruction-fetch port and the load/store port.
- Accepts the simple level-request / pulse-response handshake used by the fetch and LSU stages, and drives one AXI-lite-style master towards the crossbar/SoC.
- Exactly one transaction is outstanding at a time; ownership is round-robin.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb is DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ifu_araddr  in  ADDR_W  fetch read address
ifu_arvalid  in  1  fetch read request, held until ifu_rvalid
ifu_rdata  out  DATA_W  fetch read data
ifu_rvalid  out  1  one-cycle fetch response pulse
ifu_rerr  out  1  with ifu_rvalid: nonzero rresp
lsu_araddr  in  ADDR_W  LSU read address
lsu_arvalid  in  1  LSU read request, held until lsu_rvalid
lsu_rdata  out  DATA_W  LSU read data
lsu_rvalid  out  1  one-cycle LSU read response pulse
lsu_awaddr  in  ADDR_W  LSU write address
lsu_awvalid  in  1  LSU write request, held until lsu_bvalid
lsu_wdata  in  DATA_W  write data
lsu_wstrb  in  DATA_W/8  byte strobes
lsu_bvalid  out  1  one-cycle write completion pulse
lsu_err  out  1  with lsu_rvalid/lsu_bvalid: nonzero resp
m_araddr, m_arvalid / m_arready  out, out / in  ADDR_W, 1 / 1  master read address
m_rdata, m_rresp, m_rvalid / m_rready  in, in, in / out  DATA_W, 2, 1 / 1  master read data
m_awaddr, m_awvalid / m_awready  out, out / in  ADDR_W, 1 / 1  master write address
m_wdata, m_wstrb, m_wvalid / m_wready  out, out, out / in  DATA_W, DATA_W/8, 1 / 1  master write data
m_bresp, m_bvalid / m_bready  in, in / out  2, 1 / 1  master write response

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. All m_* valid/ready outputs come from registers.
- Reset (rst=0, async):
  - state=IDLE; all m_*valid, m_rready, m_bready = 0; all requester pulses 0.
  - last_owner=LSU, so IFU wins the first tie.
  - A reset mid-transaction abandons it; no response pulse is issued.
- IDLE arbitration:
  - Request set: IFU read, LSU read, LSU write.
  - Within the LSU, write beats read if both are asserted.
  - If IFU and LSU both request, grant the requester that is not last_owner.
  - On grant: latch address, data and strobe into internal registers, update last_owner, then go to RD_ADDR or WR_ADDR.
  - The corresponding m_arvalid or m_awvalid+m_wvalid rise the next cycle.
- RD_ADDR: hold m_arvalid until m_arready=1, then go to RD_DATA with m_rready=1.
- RD_DATA:
  - On m_rvalid, pass m_rdata combinationally to the owner's rdata.
  - In the same cycle, pulse the owner's rvalid for exactly 1 cycle and set err = (m_rresp!=0).
  - Next state IDLE.
- WR_ADDR:
  - m_awvalid and m_wvalid drop independently on their own handshakes, which may land in the same or different cycles.
  - When both are done, go to WR_RESP with m_bready=1.
- WR_RESP: on m_bvalid, pulse lsu_bvalid for 1 cycle with lsu_err = (m_bresp!=0), then go to IDLE.
- Latency: minimum read is request at cycle 0 → m_arvalid at cycle 1 → response pulse at cycle 2 (arready at 1, rvalid at 2). IDLE is revisited for 1 cycle between transactions.
- Requester inputs are ignored after grant. If a requester drops its valid mid-transaction, the transaction still completes and the pulse is still issued.
- Non-owner outputs:
  - Their rvalid/bvalid/err stay 0.
  - ifu_rdata and lsu_rdata both mirror m_rdata; consumers qualify with their own valid.
- A stray m_rvalid or m_bvalid outside RD_DATA/WR_RESP is ignored.
- No timeout; a hung slave stalls the arbiter.

Decomposition:
- Shared package:
  - state encoding constants (3-bit).
  - owner encoding (IFU=0, LSU=1).
  - AXI resp codes (OKAY=0, SLVERR=2, DECERR=3).
- One sub-module, ysyx_rr_arb2:
  - combinational 2-way round-robin picker.
  - inputs: req[1:0], last_owner; output: one-hot gnt.
  - the FSM stays in ysyx_bus_arb.

Test Plan:
- IFU read 0x8000_0000, slave arready=1 and returns 0xDEADBEEF one cycle later → m_arvalid at cycle 1, ifu_rvalid pulse at cycle 2 with ifu_rdata=0xDEADBEEF, lsu_rvalid=0.
- IFU and LSU reads both asserted in the same cycle after reset → IFU served first, LSU next. Repeat both asserted → order alternates IFU, LSU, IFU, LSU.
- LSU write 0x8000_0100, data 0x1234_5678, strb 0xF; awready at cycle 2, wready at cycle 4, bvalid at cycle 6 → m_awvalid drops after cycle 2, m_wvalid after cycle 4, single lsu_bvalid pulse at cycle 6.
- LSU read with m_rresp=2 → lsu_rvalid=1 and lsu_err=1 for one cycle, then IDLE. Next IFU read gets ifu_rerr=0.
- rst driven low while in RD_DATA (between clock edges) → m_rready and all valids 0 immediately. Stray m_rvalid after release produces no pulse, and a new IFU request is granted normally.
- lsu_arvalid and lsu_awvalid asserted together → write performed first, then read; exactly one bvalid pulse followed by one rvalid pulse.
